divn_seq_divider: RTL and testbench

//   Generalised successor to the fixed divide-by-3 datapath: unsigned SIZE-bit

---
 rtl/div_pkg.sv | 15 +
 rtl/div_restore_step.sv | 20 ++
 rtl/divn_seq_divider.sv | 105 ++++++++++
 tb/tb_divn_seq_divider.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Width of a down-counter that must hold n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring division step: bring in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module div_restore_step #(
  parameter int DIV_W = 8
) (
  input  logic [DIV_W-1:0] rem,
  input  logic             dvd_msb,
  input  logic [DIV_W-1:0] dsr,
  output logic [DIV_W-1:0] rem_nxt,
  output logic             q_bit
);

  logic [DIV_W:0] p;

  assign p       = {rem, dvd_msb};
  assign q_bit   = (p >= {1'b0, dsr});
  // rem < dsr on entry, so the difference always fits back in DIV_W bits.
  assign rem_nxt = q_bit ? DIV_W'(p - {1'b0, dsr}) : p[DIV_W-1:0];

endmodule

// File: rtl/divn_seq_divider.sv
// Unsigned SIZE/DIV_W sequential divider, one quotient bit per clock, with
// valid/ready handshakes and a divide-by-zero flag.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | resolving one quotient bit per edge, MSB first
// DONE  | result presented, waiting for out_ready
module divn_seq_divider
  import div_pkg::*;
#(
  parameter int SIZE  = 20,
  parameter int DIV_W = 8
) (
  input  logic             sys_clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  divident,
  input  logic [DIV_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  quotient,
  output logic [DIV_W-1:0] reminder,
  output logic             div_zero
);

  localparam int CNT_W = cnt_width(SIZE);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [SIZE-1:0]  dvd;
  logic [DIV_W-1:0] dsr;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] rem_nxt;
  logic             q_bit;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  div_restore_step #(.DIV_W(DIV_W)) u_step (
    .rem     (rem),
    .dvd_msb (dvd[SIZE-1]),
    .dsr     (dsr),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      quotient <= '0;
      reminder <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvd <= divident;
            dsr <= divisor;
            rem <= '0;
            cnt <= CNT_W'(SIZE - 1);
            if (divisor == '0) begin
              quotient <= '1;
              reminder <= '0;
              div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          // The dividend register doubles as the quotient shift register.
          dvd <= {dvd[SIZE-2:0], q_bit};
          rem <= rem_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient <= {dvd[SIZE-2:0], q_bit};
            reminder <= rem_nxt;
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divn_seq_divider.sv
// Directed and random checks of divn_seq_divider against plain integer
// division, including handshake stalls and a mid-operation reset.
module tb_divn_seq_divider;

  localparam int SIZE  = 20;
  localparam int DIV_W = 8;

  logic             sys_clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [SIZE-1:0]  divident;
  logic [DIV_W-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  quotient;
  logic [DIV_W-1:0] reminder;
  logic             div_zero;

  int n_assert = 0;
  int n_fail   = 0;

  divn_seq_divider #(.SIZE(SIZE), .DIV_W(DIV_W)) dut (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .divident  (divident),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .reminder  (reminder),
    .div_zero  (div_zero)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one operation, check latency and result, stall out_ready for
  // hold_cycles, then complete the handshake.
  task automatic run_op(input string tag, input logic [SIZE-1:0] a,
                        input logic [DIV_W-1:0] b, input int hold_cycles);
    int unsigned exp_q, exp_r, exp_lat;
    logic        exp_dz;
    int          lat;
    if (b == 0) begin
      exp_q = (1 << SIZE) - 1; exp_r = 0; exp_dz = 1'b1; exp_lat = 0;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_dz = 1'b0; exp_lat = SIZE;
    end
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    divident = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge sys_clock); #1;
    in_valid = 1'b0;
    divident = SIZE'($urandom);
    divisor  = DIV_W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge sys_clock); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " quotient"}, 32'(quotient), 32'(exp_q));
    chk({tag, " reminder"}, 32'(reminder), 32'(exp_r));
    chk({tag, " div_zero"}, 32'(div_zero), 32'(exp_dz));
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge sys_clock); #1;
      chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " hold quotient"}, 32'(quotient), 32'(exp_q));
      chk({tag, " hold reminder"}, 32'(reminder), 32'(exp_r));
    end
    out_ready = 1'b1;
    @(posedge sys_clock); #1;
    out_ready = 1'b0;
    chk({tag, " valid drop"}, 32'(out_valid), 32'd0);
    chk({tag, " keep quotient"}, 32'(quotient), 32'(exp_q));
  endtask

  initial begin
    int seen_valid;
    logic [SIZE-1:0]  ra;
    logic [DIV_W-1:0] rb;

    reset_n   = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    divident  = 20'd5;
    divisor   = 8'd1;
    repeat (3) @(posedge sys_clock);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset reminder", 32'(reminder), 32'd0);
    chk("reset div_zero", 32'(div_zero), 32'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(posedge sys_clock); #1;

    run_op("t1 1000000/3", 20'd1000000, 8'd3, 0);
    chk("t1 exact quotient", 32'(quotient), 32'd333333);
    run_op("t2 max/255", 20'hFFFFF, 8'd255, 0);
    chk("t2 exact reminder", 32'(reminder), 32'd15);
    run_op("t2 max/7", 20'hFFFFF, 8'd7, 0);
    run_op("t3 2/5", 20'd2, 8'd5, 0);
    run_op("t3 12345/1", 20'd12345, 8'd1, 0);
    run_op("t4 77/0", 20'd77, 8'd0, 0);
    run_op("t5 stall", 20'hFFFFF, 8'd7, 10);
    run_op("t5 back2back", 20'd999, 8'd10, 0);

    for (int k = 0; k < 24; k++) begin
      ra = SIZE'($urandom);
      rb = (k % 6 == 5) ? 8'd0 : DIV_W'($urandom_range(1, 255));
      run_op("rand", ra, rb, int'($urandom_range(0, 3)));
    end

    run_op("pre-abort", 20'hFFFFF, 8'd255, 0);
    divident = 20'd1000000;
    divisor  = 8'd3;
    in_valid = 1'b1;
    @(posedge sys_clock); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge sys_clock);
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort quotient", 32'(quotient), 32'd0);
    chk("abort reminder", 32'(reminder), 32'd0);
    chk("abort div_zero", 32'(div_zero), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge sys_clock);
    #1;
    in_valid = 1'b0;
    reset_n  = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < SIZE + 5; i++) begin
      @(posedge sys_clock); #1;
      if (out_valid) seen_valid++;
    end
    chk("abort no stale valid", 32'(seen_valid), 32'd0);
    run_op("t6 9/3", 20'd9, 8'd3, 0);
    chk("t6 exact quotient", 32'(quotient), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
